mc_control_fsm: RTL and testbench

Parametrised multicycle MIPS control unit: the next generation of the datapath sequencer. Decodes the 6-bit opcode and steps the datapath through fetch, decode, execute, memory and writeback. Adds memory wait-state handshaking, immediate-logic ops (andi/ori/slti), jal, illegal-opcode detection and fully defined, latch-free outputs in every state. Sits between the instruction register and the multicycle datapath, and drives all of the datapath's mux selects and write enables.

---
 rtl/mc_ctrl_pkg.sv | 54 +++++
 rtl/mc_op_decode.sv | 49 ++++
 rtl/mc_control_fsm.sv | 169 ++++++++++++++++
 tb/tb_mc_control_fsm.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// Holds the state enum, the opcodes and the datapath select codes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_BNE    = 4'd9,
        S_IMMEX  = 4'd10,
        S_IMMWB  = 4'd11,
        S_JUMP   = 4'd12,
        S_JAL    = 4'd13
    } mc_state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_op_decode.sv
// Combinational opcode decoder: dispatch target out of DECODE, the ALU op and
// zero-extend flag for immediate instructions, and the illegal-opcode flag.
module mc_op_decode
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [OP_W-1:0] op_i,
    output mc_state_t       dispatch_o,
    output logic [2:0]      imm_aluop_o,
    output logic            imm_zext_o,
    output logic            mem_is_load_o,
    output logic            illegal_o
);

    always_comb begin
        dispatch_o    = S_FETCH;
        imm_aluop_o   = ALU_ADD;
        imm_zext_o    = 1'b0;
        illegal_o     = 1'b0;
        mem_is_load_o = (op_i == OP_W'(OP_LW));
        case (op_i)
            OP_W'(OP_LW),
            OP_W'(OP_SW):    dispatch_o = S_MEMADR;
            OP_W'(OP_RTYPE): dispatch_o = S_EXEC;
            OP_W'(OP_BEQ):   dispatch_o = S_BEQ;
            OP_W'(OP_BNE):   dispatch_o = S_BNE;
            OP_W'(OP_ADDI):  dispatch_o = S_IMMEX;
            OP_W'(OP_ANDI): begin
                dispatch_o  = S_IMMEX;
                imm_aluop_o = ALU_AND;
                imm_zext_o  = 1'b1;
            end
            OP_W'(OP_ORI): begin
                dispatch_o  = S_IMMEX;
                imm_aluop_o = ALU_OR;
                imm_zext_o  = 1'b1;
            end
            OP_W'(OP_SLTI): begin
                dispatch_o  = S_IMMEX;
                imm_aluop_o = ALU_SLT;
            end
            OP_W'(OP_J):     dispatch_o = S_JUMP;
            OP_W'(OP_JAL):   dispatch_o = S_JAL;
            default:         illegal_o  = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives every datapath select and write enable from the current state.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3,
    parameter bit WAIT_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    op,
    input  logic               mem_ready,
    output logic               MemWrite,
    output logic               MemRead,
    output logic               IRWrite,
    output logic               MemToReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic               BeQ,
    output logic               BnE,
    output logic               PCWrite,
    output logic               ImmZext,
    output logic [1:0]         RegDst,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSrc,
    output logic [ALUOP_W-1:0] ALUop,
    output logic               illegal_op,
    output logic [3:0]         state_o
);

    mc_state_t  state_q;
    mc_state_t  state_d;
    mc_state_t  dec_dispatch;
    logic [2:0] dec_imm_aluop;
    logic [2:0] alu_sel;
    logic       dec_imm_zext;
    logic       dec_is_load;
    logic       dec_illegal;
    logic       mem_rdy;

    mc_op_decode #(.OP_W(OP_W)) u_decode (
        .op_i          (op),
        .dispatch_o    (dec_dispatch),
        .imm_aluop_o   (dec_imm_aluop),
        .imm_zext_o    (dec_imm_zext),
        .mem_is_load_o (dec_is_load),
        .illegal_o     (dec_illegal)
    );

    assign mem_rdy = !WAIT_EN || mem_ready;
    assign state_o = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = S_FETCH;
        MemWrite   = 1'b0;
        MemRead    = 1'b0;
        IRWrite    = 1'b0;
        MemToReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        BeQ        = 1'b0;
        BnE        = 1'b0;
        PCWrite    = 1'b0;
        ImmZext    = 1'b0;
        RegDst     = REGDST_RT;
        ALUSrcB    = SRCB_REG;
        PCSrc      = PCSRC_ALU;
        alu_sel    = ALU_ADD;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_rdy;
                PCWrite = mem_rdy;
                state_d = mem_rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB    = SRCB_IMMSH;
                illegal_op = dec_illegal;
                state_d    = dec_dispatch;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = dec_is_load ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                state_d = mem_rdy ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                MemToReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                state_d  = mem_rdy ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                alu_sel = ALU_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst   = REGDST_RD;
                RegWrite = 1'b1;
            end
            S_BEQ, S_BNE: begin
                ALUSrcA = 1'b1;
                alu_sel = ALU_SUB;
                PCSrc   = PCSRC_ALUOUT;
                BeQ     = (state_q == S_BEQ);
                BnE     = (state_q == S_BNE);
            end
            S_IMMEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                alu_sel = dec_imm_aluop;
                ImmZext = dec_imm_zext;
                state_d = S_IMMWB;
            end
            S_IMMWB: begin
                RegWrite = 1'b1;
                ImmZext  = dec_imm_zext;
            end
            S_JUMP: begin
                PCSrc   = PCSRC_JUMP;
                PCWrite = 1'b1;
            end
            S_JAL: begin
                PCSrc    = PCSRC_JUMP;
                PCWrite  = 1'b1;
                RegDst   = REGDST_RA;
                RegWrite = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        // Reset holds FETCH but must not leak its read strobe or ready-gated writes.
        if (!rst) begin
            MemWrite   = 1'b0;
            MemRead    = 1'b0;
            IRWrite    = 1'b0;
            MemToReg   = 1'b0;
            RegWrite   = 1'b0;
            ALUSrcA    = 1'b0;
            BeQ        = 1'b0;
            BnE        = 1'b0;
            PCWrite    = 1'b0;
            ImmZext    = 1'b0;
            RegDst     = REGDST_RT;
            ALUSrcB    = SRCB_REG;
            PCSrc      = PCSRC_ALU;
            alu_sel    = ALU_ADD;
            illegal_op = 1'b0;
        end
        ALUop = ALUOP_W'(alu_sel);
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class cycle by cycle
// against hand-computed state and control vectors.
module tb_mc_control_fsm;

    logic       clk;
    logic       rst;
    logic [5:0] op;
    logic       mem_ready;
    logic       MemWrite, MemRead, IRWrite, MemToReg, RegWrite;
    logic       ALUSrcA, BeQ, BnE, PCWrite, ImmZext, illegal_op;
    logic [1:0] RegDst, ALUSrcB, PCSrc;
    logic [2:0] ALUop;
    logic [3:0] state_o;
    logic [19:0] ctl;

    int checks = 0;
    int errors = 0;

    // Flags: MemWrite MemRead IRWrite MemToReg RegWrite ALUSrcA BeQ BnE PCWrite ImmZext
    // then RegDst, ALUSrcB, PCSrc, ALUop, illegal_op.
    localparam logic [19:0] E_ZERO  = 20'h0;
    localparam logic [19:0] E_FR    = {10'b0110000010, 2'b00, 2'b01, 2'b00, 3'b000, 1'b0};
    localparam logic [19:0] E_FW    = {10'b0100000000, 2'b00, 2'b01, 2'b00, 3'b000, 1'b0};
    localparam logic [19:0] E_DEC   = {10'b0000000000, 2'b00, 2'b11, 2'b00, 3'b000, 1'b0};
    localparam logic [19:0] E_ILL   = {10'b0000000000, 2'b00, 2'b11, 2'b00, 3'b000, 1'b1};
    localparam logic [19:0] E_MA    = {10'b0000010000, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0};
    localparam logic [19:0] E_MRD   = {10'b0100000000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [19:0] E_MWB   = {10'b0001100000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [19:0] E_MWR   = {10'b1000000000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [19:0] E_EXEC  = {10'b0000010000, 2'b00, 2'b00, 2'b00, 3'b010, 1'b0};
    localparam logic [19:0] E_ALUWB = {10'b0000100000, 2'b01, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [19:0] E_BEQ   = {10'b0000011000, 2'b00, 2'b00, 2'b01, 3'b001, 1'b0};
    localparam logic [19:0] E_BNE   = {10'b0000010100, 2'b00, 2'b00, 2'b01, 3'b001, 1'b0};
    localparam logic [19:0] E_JUMP  = {10'b0000000010, 2'b00, 2'b00, 2'b10, 3'b000, 1'b0};
    localparam logic [19:0] E_JAL   = {10'b0000100010, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0};
    localparam logic [19:0] E_IXADD = {10'b0000010000, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0};
    localparam logic [19:0] E_IXAND = {10'b0000010001, 2'b00, 2'b10, 2'b00, 3'b011, 1'b0};
    localparam logic [19:0] E_IXOR  = {10'b0000010001, 2'b00, 2'b10, 2'b00, 3'b100, 1'b0};
    localparam logic [19:0] E_IXSLT = {10'b0000010000, 2'b00, 2'b10, 2'b00, 3'b101, 1'b0};
    localparam logic [19:0] E_IWZ   = {10'b0000100001, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [19:0] E_IWN   = {10'b0000100000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};

    assign ctl = {MemWrite, MemRead, IRWrite, MemToReg, RegWrite, ALUSrcA, BeQ, BnE,
                  PCWrite, ImmZext, RegDst, ALUSrcB, PCSrc, ALUop, illegal_op};

    mc_control_fsm #(.OP_W(6), .ALUOP_W(3), .WAIT_EN(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .mem_ready  (mem_ready),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .IRWrite    (IRWrite),
        .MemToReg   (MemToReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .BeQ        (BeQ),
        .BnE        (BnE),
        .PCWrite    (PCWrite),
        .ImmZext    (ImmZext),
        .RegDst     (RegDst),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .ALUop      (ALUop),
        .illegal_op (illegal_op),
        .state_o    (state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tasks start mid-cycle (2 units after a rising edge) with the FSM in FETCH.
    task automatic test_reset();
        rst = 1'b0; op = 6'd0; mem_ready = 1'b1;
        #3;
        checks++;
        if ({state_o, ctl} !== {4'd0, E_ZERO}) begin
            errors++;
            $display("FAIL reset_hold state %0d ctl %h required state 0 ctl %h", state_o, ctl, E_ZERO);
        end
        @(posedge clk); #2;
        checks++;
        if ({state_o, ctl} !== {4'd0, E_ZERO}) begin
            errors++;
            $display("FAIL reset_edge state %0d ctl %h required state 0 ctl %h", state_o, ctl, E_ZERO);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({state_o, ctl} !== {4'd0, E_FR}) begin
            errors++;
            $display("FAIL reset_release state %0d ctl %h required state 0 ctl %h", state_o, ctl, E_FR);
        end
        $display("reset: state %0d ctl %h", state_o, ctl);
    endtask

    task automatic test_lw();
        logic [3:0]  st [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        logic [19:0] ex [5] = '{E_FR, E_DEC, E_MA, E_MRD, E_MWB};
        op = 6'b100011; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({state_o, ctl} !== {st[i], ex[i]}) begin
                errors++;
                $display("FAIL lw cyc %0d state %0d ctl %h required state %0d ctl %h", i, state_o, ctl, st[i], ex[i]);
            end
            @(posedge clk); #2;
        end
        checks++;
        if (state_o !== 4'd0) begin
            errors++;
            $display("FAIL lw_latency state %0d required 0", state_o);
        end
        $display("lw: 5 cycles, back in state %0d", state_o);
    endtask

    task automatic test_sw_wait();
        logic [3:0]  st  [7] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5};
        logic [19:0] ex  [7] = '{E_FR, E_DEC, E_MA, E_MWR, E_MWR, E_MWR, E_MWR};
        logic        rdy [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        op = 6'b101011;
        for (int i = 0; i < 7; i++) begin
            mem_ready = rdy[i];
            #1;
            checks++;
            if ({state_o, ctl} !== {st[i], ex[i]}) begin
                errors++;
                $display("FAIL sw_wait cyc %0d state %0d ctl %h required state %0d ctl %h", i, state_o, ctl, st[i], ex[i]);
            end
            @(posedge clk); #2;
        end
        checks++;
        if (state_o !== 4'd0) begin
            errors++;
            $display("FAIL sw_latency state %0d required 0", state_o);
        end
        mem_ready = 1'b1;
        $display("sw with 3 wait cycles: back in state %0d", state_o);
    endtask

    task automatic test_fetch_wait();
        logic [3:0]  st  [6] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd6, 4'd7};
        logic [19:0] ex  [6] = '{E_FW, E_FW, E_FR, E_DEC, E_EXEC, E_ALUWB};
        logic        rdy [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        op = 6'b000000;
        for (int i = 0; i < 6; i++) begin
            mem_ready = rdy[i];
            #1;
            checks++;
            if ({state_o, ctl} !== {st[i], ex[i]}) begin
                errors++;
                $display("FAIL fetch_wait cyc %0d state %0d ctl %h required state %0d ctl %h", i, state_o, ctl, st[i], ex[i]);
            end
            @(posedge clk); #2;
        end
        checks++;
        if (state_o !== 4'd0) begin
            errors++;
            $display("FAIL rtype_latency state %0d required 0", state_o);
        end
        $display("R-type after 2 fetch waits: back in state %0d", state_o);
    endtask

    task automatic test_three_cycle();
        logic [5:0]  ops [4] = '{6'b000100, 6'b000101, 6'b000010, 6'b000011};
        logic [3:0]  st3 [4] = '{4'd8, 4'd9, 4'd12, 4'd13};
        logic [19:0] ex3 [4] = '{E_BEQ, E_BNE, E_JUMP, E_JAL};
        logic [3:0]  st  [3];
        logic [19:0] ex  [3];
        mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            op = ops[k];
            st = '{4'd0, 4'd1, st3[k]};
            ex = '{E_FR, E_DEC, ex3[k]};
            for (int i = 0; i < 3; i++) begin
                #1;
                checks++;
                if ({state_o, ctl} !== {st[i], ex[i]}) begin
                    errors++;
                    $display("FAIL op%b cyc %0d state %0d ctl %h required state %0d ctl %h", ops[k], i, state_o, ctl, st[i], ex[i]);
                end
                @(posedge clk); #2;
            end
            checks++;
            if (state_o !== 4'd0) begin
                errors++;
                $display("FAIL op%b_latency state %0d required 0", ops[k], state_o);
            end
            $display("op %b: 3 cycles, back in state %0d", ops[k], state_o);
        end
    endtask

    task automatic test_imm();
        logic [5:0]  ops [4] = '{6'b001000, 6'b001100, 6'b001101, 6'b001010};
        logic [19:0] exx [4] = '{E_IXADD, E_IXAND, E_IXOR, E_IXSLT};
        logic [19:0] exw [4] = '{E_IWN, E_IWZ, E_IWZ, E_IWN};
        logic [3:0]  st  [4] = '{4'd0, 4'd1, 4'd10, 4'd11};
        logic [19:0] ex  [4];
        mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            op = ops[k];
            ex = '{E_FR, E_DEC, exx[k], exw[k]};
            for (int i = 0; i < 4; i++) begin
                #1;
                checks++;
                if ({state_o, ctl} !== {st[i], ex[i]}) begin
                    errors++;
                    $display("FAIL imm%b cyc %0d state %0d ctl %h required state %0d ctl %h", ops[k], i, state_o, ctl, st[i], ex[i]);
                end
                @(posedge clk); #2;
            end
            checks++;
            if (state_o !== 4'd0) begin
                errors++;
                $display("FAIL imm%b_latency state %0d required 0", ops[k], state_o);
            end
            $display("imm op %b: 4 cycles, back in state %0d", ops[k], state_o);
        end
    endtask

    task automatic test_illegal();
        logic [3:0]  st [2] = '{4'd0, 4'd1};
        logic [19:0] ex [2] = '{E_FR, E_ILL};
        op = 6'b111111; mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({state_o, ctl} !== {st[i], ex[i]}) begin
                errors++;
                $display("FAIL illegal cyc %0d state %0d ctl %h required state %0d ctl %h", i, state_o, ctl, st[i], ex[i]);
            end
            @(posedge clk); #2;
        end
        #1;
        checks++;
        if ({state_o, ctl} !== {4'd0, E_FR}) begin
            errors++;
            $display("FAIL illegal_after state %0d ctl %h required state 0 ctl %h", state_o, ctl, E_FR);
        end
        $display("illegal op: pulse in DECODE, back in state %0d", state_o);
    endtask

    task automatic test_reset_mid();
        op = 6'b100011; mem_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #2;
        end
        mem_ready = 1'b0;
        #1;
        checks++;
        if ({state_o, ctl} !== {4'd3, E_MRD}) begin
            errors++;
            $display("FAIL mid_memrd state %0d ctl %h required state 3 ctl %h", state_o, ctl, E_MRD);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({state_o, ctl} !== {4'd0, E_ZERO}) begin
            errors++;
            $display("FAIL mid_async state %0d ctl %h required state 0 ctl %h", state_o, ctl, E_ZERO);
        end
        mem_ready = 1'b1;
        @(posedge clk); #2;
        checks++;
        if ({state_o, ctl} !== {4'd0, E_ZERO}) begin
            errors++;
            $display("FAIL mid_held state %0d ctl %h required state 0 ctl %h", state_o, ctl, E_ZERO);
        end
        rst = 1'b1;
        op = 6'b111111;
        #1;
        checks++;
        if ({state_o, ctl} !== {4'd0, E_FR}) begin
            errors++;
            $display("FAIL mid_release state %0d ctl %h required state 0 ctl %h", state_o, ctl, E_FR);
        end
        @(posedge clk); #2;
        checks++;
        if ({state_o, ctl} !== {4'd1, E_ILL}) begin
            errors++;
            $display("FAIL mid_resume state %0d ctl %h required state 1 ctl %h", state_o, ctl, E_ILL);
        end
        @(posedge clk); #2;
        $display("reset in MEMRD: aborted, resumed to state %0d", state_o);
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_fetch_wait();
        test_three_cycle();
        test_imm();
        test_illegal();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
